// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory target (responder side of the load/store interface).
// Accepts one word-wide load or store at a time, inserts LATENCY wait states,
// then holds the response until the requester accepts it.
//
// Ports:
//   clk                       clock, rising edge
//   rst                       asynchronous reset, active low
//   req_valid / req_ready     request handshake
//   req_we                    1 = store, 0 = load
//   req_addr                  byte address
//   req_wdata                 store data, byte 0 = bits 7:0
//   req_be                    byte-lane write enables (stores only)
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata                 load data; 0 for stores and errors
//   rsp_err                   access error (out of range, or misaligned when checked)
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned loads and
// store byte-enable patterns that do not match the address as errors.
//
// State table:
//   state    | meaning
//   S_IDLE   | ready for a request; captures it on handshake
//   S_WAIT   | counting down wait states
//   S_ACCESS | one cycle: decode, read or write memory, register response
//   S_RESP   | response presented until rsp_ready
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          align_err;
    logic          acc_err;
    logic          do_write;

    // Decode of the captured request; only consumed in S_ACCESS.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        // Explicit lower-bound compare: the subtraction alone can wrap into range
        // when BASE_ADDR sits near the top of the address space.
        in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        word_idx = offset[AW+1:2];
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        align_err = 1'b0;
        if (!we_q) begin
            align_err = (addr_q[1:0] != 2'd0);
        end else begin
            case (be_q)
                4'b0000: align_err = 1'b0;   // no-op store stays a legal ack
                4'b0001: align_err = (addr_q[1:0] != 2'd0);
                4'b0010: align_err = (addr_q[1:0] != 2'd1);
                4'b0100: align_err = (addr_q[1:0] != 2'd2);
                4'b1000: align_err = (addr_q[1:0] != 2'd3);
                4'b0011: align_err = (addr_q[1:0] != 2'd0);
                4'b1100: align_err = (addr_q[1:0] != 2'd2);
                4'b1111: align_err = (addr_q[1:0] != 2'd0);
                default: align_err = 1'b1;
            endcase
        end
    end
`else
    always_comb begin
        align_err = 1'b0;
    end
`endif

    always_comb begin
        acc_err  = !in_range || align_err;
        do_write = (state == S_ACCESS) && we_q && !acc_err && (be_q != 4'b0000);
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        wait_cnt  <= LAT_INIT;
                        state     <= (LATENCY == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= acc_err;
                    rsp_rdata <= (!we_q && !acc_err) ? mem[word_idx] : 32'd0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
